// File: rtl/ldpc15_pkg.sv
// Shared constants, FSM state type and H715 parity-check rows for the (15,7)
// cyclic code; imported by the encoder and the downstream majority-logic corrector.
package ldpc15_pkg;

  localparam int N = 15;
  localparam int K = 7;
  localparam logic [8:0] G_POLY = 9'h1D1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Row i checks parity bit cw[i] against the message bits that feed it.
  localparam logic [7:0][14:0] H715_ROWS = {
    15'h4580,  // row 7: bits 7, 8, 10, 14
    15'h6740,  // row 6: bits 6, 8, 9, 10, 13, 14
    15'h7620,  // row 5: bits 5, 9, 10, 12, 13, 14
    15'h3B10,  // row 4: bits 4, 8, 9, 11, 12, 13
    15'h5808,  // row 3: bits 3, 11, 12, 14
    15'h2C04,  // row 2: bits 2, 10, 11, 13
    15'h1602,  // row 1: bits 1, 9, 10, 12
    15'h0B01   // row 0: bits 0, 8, 9, 11
  };

  function automatic logic [7:0] h715_syndrome(input logic [14:0] c);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      s[i] = ^(c & H715_ROWS[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/ldpc15_lfsr_div.sv
// Serial polynomial divider by g(x); after K shifts r holds the parity remainder.
module ldpc15_lfsr_div
  import ldpc15_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       din,
  output logic [7:0] r
);

  logic w_fb;

  assign w_fb = din ^ r[7];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= 8'h00;
    end else if (clr) begin
      r <= 8'h00;
    end else if (shift_en) begin
      r <= {r[6:0], 1'b0} ^ (w_fb ? G_POLY[7:0] : 8'h00);
    end
  end

endmodule

// File: rtl/ldpc15_encoder.sv
// Systematic (15,7) cyclic encoder with valid/ready in and out.
// Optional self-check syndrome enabled by defining LDPC15_ENC_SELFCHECK_EN.
module ldpc15_encoder
  import ldpc15_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] cw,
  output logic         chk_err
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [K-1:0] r_msg;
  logic [2:0]   r_step;
  logic [7:0]   w_rem;
  logic         w_clr;
  logic         w_shift;

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_clr       = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_step == 3'd6) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Rotating the message K times feeds it MSB first and leaves it back in
  // place, so no separate holding register is needed for the codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_msg  <= '0;
      r_step <= 3'd0;
    end else if (w_clr) begin
      r_msg  <= msg;
      r_step <= 3'd0;
    end else if (w_shift) begin
      r_msg <= {r_msg[K-2:0], r_msg[K-1]};
      if (r_step != 3'd6) begin
        r_step <= r_step + 3'd1;
      end
    end
  end

  ldpc15_lfsr_div u_lfsr_div (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .shift_en (w_shift),
    .din      (r_msg[K-1]),
    .r        (w_rem)
  );

  assign cw = {r_msg, w_rem};

`ifdef LDPC15_ENC_SELFCHECK_EN
  assign chk_err = (|h715_syndrome(cw)) && out_valid;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ldpc15_encoder.sv
// Directed and random checks of ldpc15_encoder: codewords, latency,
// backpressure, mid-shift reset and acceptance spacing.
module tb_ldpc15_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  msg;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] cw;
  logic        chk_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [6:0]  m;
    logic [14:0] exp_cw;
  } vec_t;

  vec_t vecs[6];

  ldpc15_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msg       (msg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cw        (cw),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference codeword from the parity equations, independent of any LFSR.
  function automatic logic [14:0] model_cw(input logic [6:0] m);
    logic [14:0] c;
    c = {m, 8'h00};
    c[0] = c[8] ^ c[9] ^ c[11];
    c[1] = c[9] ^ c[10] ^ c[12];
    c[2] = c[10] ^ c[11] ^ c[13];
    c[3] = c[11] ^ c[12] ^ c[14];
    c[4] = c[8] ^ c[9] ^ c[11] ^ c[12] ^ c[13];
    c[5] = c[9] ^ c[10] ^ c[12] ^ c[13] ^ c[14];
    c[6] = c[8] ^ c[9] ^ c[10] ^ c[13] ^ c[14];
    c[7] = c[8] ^ c[10] ^ c[14];
    return c;
  endfunction

  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      check({tag, " out_valid timeout"}, 32'd0, 32'd1);
    end
  endtask

  task automatic encode(input logic [6:0] m, input logic [14:0] exp, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready idle"}, in_ready, 1);
    in_valid = 1'b1;
    msg      = m;
    @(negedge clk);
    in_valid = 1'b0;
    msg      = ~m;
    wait_valid(tag, lat);
    check({tag, " latency"}, lat, 7);
    check({tag, " cw"}, cw, exp);
    check({tag, " chk_err"}, chk_err, 0);
    check({tag, " in_ready busy"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, out_valid, 0);
    check({tag, " in_ready back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int t1;
    int seen;
    logic [6:0] rm;

    vecs[0] = '{7'h00, 15'h0000};
    vecs[1] = '{7'h01, 15'h01D1};
    vecs[2] = '{7'h40, 15'h40E8};
    vecs[3] = '{7'h7F, 15'h7FFF};
    vecs[4] = '{7'h02, 15'h0273};
    vecs[5] = '{7'h55, 15'h55E5};

    rst       = 1'b1;
    in_valid  = 1'b0;
    msg       = 7'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset cw", cw, 0);
    check("reset chk_err", chk_err, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      encode(vecs[i].m, vecs[i].exp_cw, $sformatf("vec%0d", i));
    end

    // Backpressure with in_valid pulses during SHIFT and DONE.
    @(negedge clk);
    in_valid = 1'b1;
    msg      = 7'h55;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    msg      = 7'h7F;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid("bp", lat);
    check("bp cw", cw, 15'h55E5);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      msg      = 7'h7F;
      @(negedge clk);
      check($sformatf("bp hold%0d out_valid", i), out_valid, 1);
      check($sformatf("bp hold%0d cw", i), cw, 15'h55E5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release in_ready", in_ready, 1);
    check("bp release out_valid", out_valid, 0);
    encode(7'h01, 15'h01D1, "after_bp");

    // Reset on the edge closing the 4th SHIFT cycle.
    @(negedge clk);
    in_valid = 1'b1;
    msg      = 7'h7F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid out_valid", out_valid, 0);
    check("rst mid in_ready", in_ready, 1);
    check("rst mid cw", cw, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst discard out_valid count", seen, 0);
    encode(7'h01, 15'h01D1, "post_rst");

    // Back-to-back acceptances with out_ready held high.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    msg       = 7'h02;
    @(negedge clk);
    wait_valid("spacing first", lat);
    t1 = cyc;
    check("spacing first cw", cw, 15'h0273);
    @(negedge clk);
    check("spacing done one cycle", out_valid, 0);
    wait_valid("spacing second", lat);
    in_valid = 1'b0;
    check("spacing gap", cyc - t1, 9);
    check("spacing second cw", cw, 15'h0273);
    @(negedge clk);
    out_ready = 1'b0;

    // Random messages against the parity-equation model.
    for (int i = 0; i < 20; i++) begin
      rm = 7'($urandom_range(0, 127));
      encode(rm, model_cw(rm), $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ldpc15_encoder.md
# ldpc15_encoder

Systematic encoder for the (15,7) cyclic code whose parity-check matrix H715 drives the one-step majority-logic corrector. It accepts a 7-bit message over a valid/ready handshake and computes the 8 parity bits serially with an LFSR divider by g(x) = 1 + x^4 + x^6 + x^7 + x^8. It then presents the 15-bit codeword over a second valid/ready handshake. It sits on the transmit side, upstream of the channel and corrector.

## Interface
- N, 15, codeword length; only 15 is legal.
- K, 7, message length; only 7 is legal.
- G_POLY, 9'h1D1, generator polynomial, bit i = coefficient of x^i.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  msg is valid.
- in_ready  out  1  encoder can accept a message.
- msg  in  7  message; msg[6:0] maps to cw[14:8].
- out_valid  out  1  cw is valid.
- out_ready  in  1  consumer accepts cw.
- cw  out  15  codeword; cw[14:8] = message, cw[7:0] = parity.
- chk_err  out  1  self-check syndrome nonzero (see Configuration).

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: 7 cycles, in_ready=0.
  - DONE: out_valid=1.
- IDLE → SHIFT on in_valid && in_ready:
  - msg is captured into the message shift register.
  - The 8-bit remainder register r is cleared.
  - Step counter is set to 0.
- SHIFT, each cycle:
  - Message is fed MSB first (msg[6]).
  - fb = msgbit ^ r[7].
  - r <= {r[6:0],1'b0} ^ (fb ? G_POLY[7:0] : 8'h00), with G_POLY[7:0] = 8'hD1.
  - Step counter increments.
- SHIFT → DONE after step 6 (the 7th shift).
  - cw = {held msg, r}; r[i] = cw[i].
- DONE → IDLE on out_ready. cw and out_valid are stable while out_valid && !out_ready.
- in_valid outside IDLE: ignored, not captured.
- Step counter: 3 bits, counts 0..6, never wraps.
- Parity equations that must result (XOR):
  - cw0 = m8^m9^m11
  - cw1 = m9^m10^m12
  - cw2 = m10^m11^m13
  - cw3 = m11^m12^m14
  - cw4 = m8^m9^m11^m12^m13
  - cw5 = m9^m10^m12^m13^m14
  - cw6 = m8^m9^m10^m13^m14
  - cw7 = m8^m10^m14
  - Here m_j = cw[j] = msg[j-8].

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, cw=0, chk_err=0, r=0, step=0.
- Acceptance edge E0. SHIFT occupies edges E1..E7. out_valid=1 from after E7 (latency 7 cycles).
- out_ready held high: DONE lasts exactly 1 cycle. in_ready returns 1 the following cycle.
- Minimum spacing between acceptances: 9 cycles.
- rst mid-SHIFT or mid-DONE: all state returns to reset values at that edge, and any in-flight codeword is discarded. rst has priority over every handshake.
- All outputs are registered except in_ready and out_valid, which are decoded from state.

## Configuration
- LDPC15_ENC_SELFCHECK_EN defined:
  - A combinational H715 syndrome is computed on cw in DONE.
  - chk_err = |syndrome && out_valid.
  - A nonzero syndrome indicates an LFSR fault.
- Undefined:
  - chk_err is tied to 0.
  - No syndrome logic is synthesized.

## Structure
- Package ldpc15_pkg holds:
  - N, K, G_POLY.
  - The state enum {IDLE, SHIFT, DONE}.
  - The eight 15-bit H715 row masks.
- The corrector is expected to import ldpc15_pkg as well.
- One sub-module: ldpc15_lfsr_div.
  - Contains the 8-bit remainder register.
  - Ports: clr, shift_en, din, r.
- The FSM, message register and handshake live in the top module.

## Test plan
- msg=7'h00 → cw=15'h0000 after 7 cycles; chk_err=0.
- msg=7'h01 → cw=15'h01D1.
- msg=7'h40 → cw=15'h40E8.
- msg=7'h7F → cw=15'h7FFF.
- Backpressure: out_ready=0 for 5 cycles in DONE → cw/out_valid stable. in_valid pulses during DONE are ignored. Release → in_ready=1 next cycle.
- rst at 4th SHIFT cycle → out_valid stays 0. A subsequent msg=7'h01 yields 15'h01D1 with no residue.
- Random messages (with macro) → cw matches all eight parity equations above; chk_err=0 throughout.
